// File: rtl/pong_pkg.sv
// Shared types for the pong round sequencer: FSM states, player ids, speed width.
// No logic of its own; pure declarations plus one combinational helper.
// No flow control involved.
package pong_pkg;

   // Width of the ball speed bus (pixels per frame).
   localparam int SPEED_W = 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SERVE  = 3'd1,
      PLAY   = 3'd2,
      SCORED = 3'd3,
      OVER   = 3'd4
   } state_t;

   typedef enum logic {
      P1 = 1'b0,
      P2 = 1'b1
   } player_t;

   // One speed step, holding at the ceiling rather than wrapping.
   function automatic logic [SPEED_W-1:0] speed_inc(input logic [SPEED_W-1:0] cur,
                                                   input logic [SPEED_W-1:0] max);
      return (cur >= max) ? cur : cur + 1'b1;
   endfunction

endpackage

// File: rtl/pong_round_ctrl_if.sv
// Bundle between the round sequencer and the game/ball side: buttons, collision info, ball control, scores.
// Wires only, no latency.
// No backpressure; every signal is a level or a single-cycle pulse.
interface pong_round_ctrl_if #(
   parameter int SCORE_W = 4
);
   import pong_pkg::*;

   // Toward the sequencer.
   logic                 frame_tick;
   logic                 start;
   logic                 outofbounds;
   logic                 collision;
   logic                 dir_x;

   // From the sequencer.
   logic                 ball_rst;
   logic                 ball_en;
   logic [SPEED_W-1:0]   speed;
   logic [SCORE_W-1:0]   p1_score;
   logic [SCORE_W-1:0]   p2_score;
   logic                 game_over;
   logic                 winner;

   // Sequencer side.
   modport master (
      input  frame_tick, start, outofbounds, collision, dir_x,
      output ball_rst, ball_en, speed, p1_score, p2_score, game_over, winner
   );

   // Game/ball side.
   modport slave (
      output frame_tick, start, outofbounds, collision, dir_x,
      input  ball_rst, ball_en, speed, p1_score, p2_score, game_over, winner
   );

endinterface

// File: rtl/pong_round_ctrl_rise_detect.sv
// Rising-edge detector: flags a cycle where the input is 1 and was 0 the cycle before.
// Zero latency from input to rise; one register of history.
// No backpressure; a level held high yields a single pulse.
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic rise
);

   logic sig_q;

   // Remember last cycle's value of the input.
   always_ff @(posedge clk) begin
      if (reset) sig_q <= 1'b0;
      else       sig_q <= sig;
   end

   assign rise = sig & ~sig_q;

endmodule

// File: rtl/pong_round_ctrl.sv
// Pong round sequencer: serve timing, ball enable/reset, rally speed-up, scoring and win detection.
// Outputs registered; an input that changes state shows on the outputs after one clock edge.
// No backpressure; all inputs are sampled every cycle and cannot be stalled.
module pong_round_ctrl
   import pong_pkg::*;
#(
   parameter int WIN_SCORE    = 7,
   parameter int SERVE_FRAMES = 60,
   parameter int SPEEDUP_HITS = 4,
   parameter int MAX_SPEED    = 7,
   parameter int SCORE_W      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   pong_round_ctrl_if.master     io
);

   localparam int FRAME_W = $clog2(SERVE_FRAMES + 1);
   localparam int HIT_W   = $clog2(SPEEDUP_HITS + 1);

   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(SERVE_FRAMES - 1);
   localparam logic [HIT_W-1:0]   HIT_LAST   = HIT_W'(SPEEDUP_HITS - 1);
   localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
   localparam logic [SPEED_W-1:0] MAX_S      = SPEED_W'(MAX_SPEED);

   state_t               state_q, state_nxt;
   logic                 start_rise, coll_rise;
   logic [FRAME_W-1:0]   frame_cnt_q;
   logic [HIT_W-1:0]     hit_cnt_q;
   logic [SPEED_W-1:0]   speed_q;
   player_t              scorer_q;
   logic [SCORE_W-1:0]   p1_q, p2_q;
   logic                 game_over_q, winner_q;
   logic                 ball_rst_q, ball_en_q;
   logic [SCORE_W-1:0]   scorer_pts;
   logic                 enter_serve;
   logic                 new_game;
   logic                 point_won;
   logic                 hit_seen;

   rise_detect u_start_rd (
      .clk   (clk),
      .reset (reset),
      .sig   (io.start),
      .rise  (start_rise)
   );

   rise_detect u_coll_rd (
      .clk   (clk),
      .reset (reset),
      .sig   (io.collision),
      .rise  (coll_rise)
   );

   // Next-state decision plus the strobes derived from it.
   always_comb begin
      state_nxt  = state_q;
      scorer_pts = (scorer_q == P1) ? p1_q : p2_q;
      case (state_q)
         IDLE:    if (start_rise) state_nxt = SERVE;
         SERVE:   if (io.frame_tick && (frame_cnt_q == FRAME_LAST)) state_nxt = PLAY;
         PLAY:    if (io.outofbounds) state_nxt = SCORED;
         SCORED:  state_nxt = (scorer_pts == WIN_S) ? OVER : SERVE;
         OVER:    if (start_rise) state_nxt = SERVE;
         default: state_nxt = IDLE;
      endcase
      enter_serve = (state_nxt == SERVE) && (state_q != SERVE);
      new_game    = start_rise && ((state_q == IDLE) || (state_q == OVER));
      point_won   = (state_q == PLAY) && io.outofbounds;
      // A ball leaving the field in the same cycle as a hit never counts the hit.
      hit_seen    = (state_q == PLAY) && !io.outofbounds && coll_rise;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_nxt;
   end

   // Serve hold-off: count frame ticks only while waiting to serve.
   always_ff @(posedge clk) begin
      if (reset)                               frame_cnt_q <= '0;
      else if (enter_serve)                    frame_cnt_q <= '0;
      else if (state_q == SERVE && io.frame_tick) frame_cnt_q <= frame_cnt_q + 1'b1;
   end

   // Rally length tracking and ball speed-up, restarted at every serve.
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_cnt_q <= '0;
         speed_q   <= SPEED_W'(1);
      end else if (enter_serve) begin
         hit_cnt_q <= '0;
         speed_q   <= SPEED_W'(1);
      end else if (hit_seen) begin
         if (hit_cnt_q == HIT_LAST) begin
            hit_cnt_q <= '0;
            speed_q   <= speed_inc(speed_q, MAX_S);
         end else begin
            hit_cnt_q <= hit_cnt_q + 1'b1;
         end
      end
   end

   // Scores, scorer latch and game result; the point lands on the edge into SCORED.
   always_ff @(posedge clk) begin
      if (reset) begin
         scorer_q    <= P1;
         p1_q        <= '0;
         p2_q        <= '0;
         game_over_q <= 1'b0;
         winner_q    <= 1'b0;
      end else begin
         if (new_game) begin
            p1_q        <= '0;
            p2_q        <= '0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
         end
         if (point_won) begin
            // Ball exiting while moving right means it passed P2, so P1 scores.
            if (io.dir_x) begin
               scorer_q <= P1;
               if (p1_q < WIN_S) p1_q <= p1_q + 1'b1;
            end else begin
               scorer_q <= P2;
               if (p2_q < WIN_S) p2_q <= p2_q + 1'b1;
            end
         end
         if (state_q == SCORED && state_nxt == OVER) begin
            game_over_q <= 1'b1;
            winner_q    <= (scorer_q == P2);
         end
      end
   end

   // Ball control strobes, registered from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         ball_rst_q <= 1'b0;
         ball_en_q  <= 1'b0;
      end else begin
         ball_rst_q <= enter_serve;
         ball_en_q  <= (state_nxt == PLAY);
      end
   end

   assign io.ball_rst  = ball_rst_q;
   assign io.ball_en   = ball_en_q;
   assign io.speed     = speed_q;
   assign io.p1_score  = p1_q;
   assign io.p2_score  = p2_q;
   assign io.game_over = game_over_q;
   assign io.winner    = winner_q;

endmodule

// File: tb/tb_pong_round_ctrl.sv
// Directed bench for pong_round_ctrl: expectations queued as stimulus is driven, checked after each edge.
// Samples outputs 1 time unit after the rising edge.
// No backpressure on the DUT; the stimulus is cycle-exact.
module tb_pong_round_ctrl;
   import pong_pkg::*;

   localparam int SW = 4;

   typedef struct packed {
      logic          rst;
      logic          en;
      logic [2:0]    speed;
      logic [SW-1:0] p1;
      logic [SW-1:0] p2;
      logic          go;
      logic          win;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   pong_round_ctrl_if #(.SCORE_W(SW)) io ();

   pong_round_ctrl #(
      .WIN_SCORE    (3),
      .SERVE_FRAMES (2),
      .SPEEDUP_HITS (2),
      .MAX_SPEED    (3),
      .SCORE_W      (SW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .io    (io)
   );

   always #5 clk = ~clk;

   int    tests = 0;
   int    fails = 0;
   exp_t  m;
   exp_t  exp_q[$];
   string tag_q[$];

   task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_state(input string tag, input state_t s);
      tests++;
      assert (dut.state_q === s) else begin
         fails++;
         $error("FAIL %s/state: got %0d expected %0d", tag, dut.state_q, s);
      end
   endtask

   // Queue the current model, clock once, then pop and compare every output.
   task automatic tick_check(input string tag);
      exp_t  e;
      string t;
      exp_q.push_back(m);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      cmp({t, "/ball_rst"},  8'(io.ball_rst),  8'(e.rst));
      cmp({t, "/ball_en"},   8'(io.ball_en),   8'(e.en));
      cmp({t, "/speed"},     8'(io.speed),     8'(e.speed));
      cmp({t, "/p1_score"},  8'(io.p1_score),  8'(e.p1));
      cmp({t, "/p2_score"},  8'(io.p2_score),  8'(e.p2));
      cmp({t, "/game_over"}, 8'(io.game_over), 8'(e.go));
      cmp({t, "/winner"},    8'(io.winner),    8'(e.win));
   endtask

   // Two frame ticks with a gap; ball enable comes up on the edge of the second.
   task automatic serve_ticks();
      m.rst = 1'b0;
      io.frame_tick = 1'b1; tick_check("serve_tick1");
      io.frame_tick = 1'b0; tick_check("serve_gap");
      check_state("serve_wait", SERVE);
      io.frame_tick = 1'b1; m.en = 1'b1; tick_check("serve_tick2");
      io.frame_tick = 1'b0;
      check_state("serve_play", PLAY);
   endtask

   // Ball exits the field; the point shows at once, the next serve one edge later.
   task automatic point(input logic dir, input string tag);
      io.dir_x = dir; io.outofbounds = 1'b1;
      m.en = 1'b0;
      if (dir) m.p1 = m.p1 + 1'b1;
      else     m.p2 = m.p2 + 1'b1;
      tick_check(tag);
      io.outofbounds = 1'b0;
      check_state(tag, SCORED);
   endtask

   task automatic back_to_serve(input string tag);
      m.rst = 1'b1; m.speed = 3'd1;
      tick_check(tag);
      check_state(tag, SERVE);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      io.frame_tick = 1'b0; io.start = 1'b0; io.outofbounds = 1'b0;
      io.collision = 1'b0;  io.dir_x = 1'b0;
      m = '{rst: 1'b0, en: 1'b0, speed: 3'd1, p1: '0, p2: '0, go: 1'b0, win: 1'b0};

      // Reset values.
      tick_check("reset0");
      tick_check("reset1");
      check_state("reset", IDLE);
      reset = 1'b0;
      tick_check("idle");

      // Held start: one serve entry, one ball_rst cycle, no frames counted without ticks.
      io.start = 1'b1; m.rst = 1'b1;
      tick_check("start_edge");
      check_state("start_edge", SERVE);
      m.rst = 1'b0;
      for (int i = 0; i < 9; i++) tick_check("start_held");
      check_state("start_held", SERVE);
      io.start = 1'b0;
      serve_ticks();

      // A start edge in PLAY is ignored.
      io.start = 1'b1; tick_check("start_in_play");
      io.start = 1'b0; tick_check("start_release");
      check_state("start_in_play", PLAY);

      // Six 3-cycle collision pulses: speed steps on every second edge and saturates at 3.
      for (int i = 0; i < 6; i++) begin
         io.collision = 1'b1;
         if (i % 2 == 1 && m.speed < 3'd3) m.speed = m.speed + 1'b1;
         tick_check("coll_edge");
         tick_check("coll_hold1");
         tick_check("coll_hold2");
         io.collision = 1'b0;
         tick_check("coll_gap");
      end

      // P1 point, then serve restarts at speed 1 with a fresh ball_rst.
      point(1'b1, "p1_point");
      back_to_serve("p1_reserve");
      serve_ticks();

      // Hit count at 1, then out-of-bounds with a collision edge in the same cycle.
      io.collision = 1'b1; tick_check("pre_hit");
      io.collision = 1'b0; tick_check("pre_hit_gap");
      io.collision = 1'b1;
      point(1'b0, "oob_and_hit");
      io.collision = 1'b0;
      back_to_serve("p2_reserve1");
      serve_ticks();
      point(1'b0, "p2_point2");
      back_to_serve("p2_reserve2");
      serve_ticks();
      point(1'b0, "p2_point3");

      // Win: OVER with P2 as winner, no new serve.
      m.go = 1'b1; m.win = 1'b1;
      tick_check("game_over");
      check_state("game_over", OVER);

      // Stray inputs in OVER change nothing.
      io.outofbounds = 1'b1; io.frame_tick = 1'b1; io.collision = 1'b1;
      tick_check("over_stray1");
      io.frame_tick = 1'b0; io.collision = 1'b0;
      tick_check("over_stray2");
      io.outofbounds = 1'b0;
      tick_check("over_stray3");
      check_state("over_hold", OVER);

      // New game from OVER.
      io.start = 1'b1;
      m.p1 = '0; m.p2 = '0; m.go = 1'b0; m.win = 1'b0; m.rst = 1'b1;
      tick_check("restart");
      check_state("restart", SERVE);
      io.start = 1'b0;
      serve_ticks();

      // Build p1_score=2 and speed 2, then reset in the middle of play.
      point(1'b1, "p1_a");
      back_to_serve("p1_a_reserve");
      serve_ticks();
      point(1'b1, "p1_b");
      back_to_serve("p1_b_reserve");
      serve_ticks();
      io.collision = 1'b1; tick_check("mid_hit1");
      io.collision = 1'b0; tick_check("mid_gap1");
      io.collision = 1'b1; m.speed = 3'd2; tick_check("mid_hit2");
      io.collision = 1'b0; tick_check("mid_gap2");
      check_state("mid_play", PLAY);

      reset = 1'b1;
      m = '{rst: 1'b0, en: 1'b0, speed: 3'd1, p1: '0, p2: '0, go: 1'b0, win: 1'b0};
      tick_check("reset_mid");
      check_state("reset_mid", IDLE);
      cmp("reset_mid/frame_cnt", 8'(dut.frame_cnt_q), 8'd0);
      cmp("reset_mid/hit_cnt",   8'(dut.hit_cnt_q),   8'd0);
      reset = 1'b0;
      tick_check("after_reset");
      check_state("after_reset", IDLE);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pong_round_ctrl.md
Name: pong_round_ctrl

Overview:
Round/game sequencer for the pong datapath. It drives the ball-collision block's reset and the ball-motion enable, and keeps both players' scores. It also raises ball speed as a rally lengthens, and declares a winner. It sits between the top-level game FSM/button inputs and the ball position and collision logic, and runs on the pixel-domain system clock.

Parameters:
WIN_SCORE, 7, points needed to win a game
SERVE_FRAMES, 60, frame ticks the ball is held still before each serve
SPEEDUP_HITS, 4, bat/wall collisions per speed increment
MAX_SPEED, 7, saturation value of speed
SCORE_W, 4, width of each score counter (must hold WIN_SCORE)

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
start  in  1  start button, level, already synchronised
outofbounds  in  1  from collision block; ball left the playfield
collision  in  1  from collision block; ball hit wall or bat (level, may persist several cycles)
dir_x  in  1  from collision block; 1 = ball moving right (toward P2)
ball_rst  out  1  reset to collision block and ball position
ball_en  out  1  ball motion enable
speed  out  3  pixels per frame for ball motion
p1_score  out  SCORE_W  player-1 score
p2_score  out  SCORE_W  player-2 score
game_over  out  1  game finished
winner  out  1  0 = P1, 1 = P2; valid only when game_over=1

Behaviour:
- Reset values: state IDLE, ball_rst=0, ball_en=0, speed=1, both scores=0, game_over=0, winner=0, hit and frame counters=0.
- Internal rising-edge detect on start and collision: an edge is 1 when the input is 1 this cycle and was 0 last cycle.
- IDLE: ball_en=0. A start edge clears both scores and moves to SERVE.
- SERVE: ball_rst=1 for exactly the first cycle in the state, so the collision block alternates serve side once per round. ball_en=0. speed=1 and the hit counter clears on entry. Count frame_tick pulses; on the SERVE_FRAMES-th tick go to PLAY on the next cycle.
- PLAY: ball_en=1.
  - Each collision edge increments the hit counter. When it reaches SPEEDUP_HITS it clears and speed increments, saturating at MAX_SPEED.
  - When outofbounds=1, latch the scorer: dir_x=1 means P1 scores, dir_x=0 means P2 scores. Then go to SCORED.
  - If outofbounds and a collision edge occur in the same cycle, outofbounds wins and the hit is not counted.
- SCORED: lasts one cycle; ball_en=0. Increment the latched scorer's score. If the new value equals WIN_SCORE, set winner and game_over and go to OVER; otherwise go to SERVE.
- OVER: ball_en=0; game_over and winner hold; scores hold. A start edge clears scores, game_over and winner, then goes to SERVE.
- A start edge in SERVE, PLAY or SCORED is ignored. A held start produces only one edge.
- frame_tick is ignored outside SERVE.
- Reset mid-round, in any state, returns to the full reset values on the next edge; no score is awarded.
- Scores never exceed WIN_SCORE; no wrap.
- All outputs are registered; state change to output change takes one cycle.

Decomposition:
- Package pong_pkg: state enum {IDLE, SERVE, PLAY, SCORED, OVER}, speed width constant, player enum {P1=0, P2=1}.
- One sub-module, rise_detect (1-bit registered edge detector), instantiated for start and collision.
- FSM, counters and score registers stay in pong_round_ctrl.

Test Plan:
Bench parameters: WIN_SCORE=3, SERVE_FRAMES=2, SPEEDUP_HITS=2, MAX_SPEED=3.
1. Reset, then start held 10 cycles -> single SERVE entry; ball_rst high exactly 1 cycle; ball_en rises 1 cycle after the 2nd frame_tick.
2. In PLAY, 6 collision pulses each 3 cycles long -> speed steps 1→2→3 and stays 3 (saturates); hits are counted per edge, not per cycle.
3. In PLAY, outofbounds=1 with dir_x=1 -> one cycle later p1_score=1, p2_score=0; ball_en=0; back to SERVE with speed=1 and a new ball_rst pulse.
4. Three P2 points (dir_x=0) -> p2_score=3, game_over=1, winner=1; further outofbounds or frame_tick cause no change; a start edge -> scores 0, game_over=0, state SERVE.
5. Same-cycle outofbounds and collision edge at hit count 1 -> score awarded; speed unchanged.
6. Reset asserted in PLAY with p1_score=2 -> next cycle all outputs at reset values; state IDLE.
